oport_pck_arbiter: RTL and testbench
====================================

# oport_pck_arbiter

Per-output-port packet scheduler for the router crossbar. It arbitrates among the P-1 input ports competing for one output port and tracks downstream credits for each output VC. Once a multi-flit packet wins, the port stays locked to it until the tail flit is granted. It drives the registered crossbar select and write-enable for that output, one cycle after grant, matching the router's delayed-grant crossbar timing.

## Interface
Parameters:
- V, 4, output VCs per port.
- N, 4, number of requesting input ports (P-1).
- B, 4, downstream buffer depth per VC, in flits.
- Vw, log2(V) (min 1), binary VC index width (derived).
- Cw, log2(B+1), credit counter width (derived).

Ports:
- clk  in  1  router clock.
- reset  in  1  asynchronous, active-high.
- req  in  N  input i has a flit ready for this output.
- req_ovc  in  N*Vw  binary target output VC, requester i at [i*Vw +: Vw].
- req_tail  in  N  flit of requester i is a tail (single-flit packets assert it).
- credit_in  in  V  one credit returned per VC per cycle.
- grant  out  N  one-hot or zero, combinational, same cycle as req.
- xbar_sel  out  N  grant registered one cycle (crossbar select).
- flit_we_out  out  1  |grant registered one cycle.
- ovc_empty  out  V  credit_cnt[v]==0, decoded from registers.
- locked  out  1  state==LOCKED.
- credit_err  out  1  sticky: credit returned to a VC already at B.

## Operation
- Eligibility: elig[i] = req[i] & (credit_cnt[req_ovc_i] != 0).
  - IDLE: all inputs eligible.
  - LOCKED: only owner eligible.
  - Credit arriving this cycle does not make a VC eligible this cycle.
- Round-robin among elig, starting at ptr; grant = first eligible at or after ptr, wrapping N-1→0.
- FSM:
  - IDLE, grant to i with req_tail[i]=0 → LOCKED, owner←i.
  - IDLE, grant with tail → stay IDLE (single-flit packet).
  - LOCKED, owner granted with tail → IDLE.
  - LOCKED, owner idle or out of credit → stay LOCKED, grant=0.
  - Other requesters are never granted while LOCKED.
- ptr update: on every tail grant, ptr←(granted index+1) mod N; otherwise unchanged.
- Credit counters, per VC v: cnt_next = cnt - dec + inc.
  - dec = grant to a requester whose req_ovc==v.
  - inc = credit_in[v].
  - dec and inc together on the same VC → unchanged.
  - inc at cnt==B with no dec → cnt stays B, credit_err←1.
  - Counters never wrap below 0, since grant requires cnt≠0.

## Timing
- Reset values:
  - state=IDLE, owner=0, ptr=0.
  - all credit_cnt=B.
  - xbar_sel=0, flit_we_out=0, credit_err=0.
  - grant=0 while reset is held. ovc_empty=0, locked=0.
- grant: zero-latency combinational from req/req_ovc/req_tail and registered state.
- xbar_sel and flit_we_out: exactly 1 cycle after grant.
- Counters, FSM and ptr update on the clk edge of the grant cycle. ovc_empty reflects the new count the next cycle.
- Back-to-back: one grant per cycle sustained while credit is available. A lock and the next packet's head can be granted in consecutive cycles.
- Reset mid-packet: lock dropped and counters restored to B immediately (asynchronous). The upstream router is reset together with this block.

## Structure
- Shared package/header holds:
  - log2 function.
  - Vw and Cw derivations.
  - FSM encoding constants (IDLE=1'b0, LOCKED=1'b1).
- Sub-module `rr_fixed_ptr_arb` (N-wide, explicit ptr input, one-hot grant out), reused by other port schedulers.
- Credit counters built in a generate loop over V within this module.

## Test plan
- Reset, then req=4'b0101, both tail, req_ovc=0 → grant=0001 cycle 0, 0100 cycle 1; xbar_sel follows one cycle later; cnt[0]: 4→3→2.
- Input 1 sends 3-flit packet (tail on 3rd) while input 2 requests continuously → grant=0010 ×3, locked=1 for cycles 1–2, then grant=0100.
- Five single-flit grants to VC 2 with B=4, no credits → 4 grants, ovc_empty[2]=1, fifth stalls. credit_in[2] pulse → grant one cycle later.
- cnt[1]=2, grant to VC 1 and credit_in[1] same cycle → cnt[1] stays 2.
- credit_in[3] with cnt[3]=4 → cnt stays 4, credit_err=1 until reset.
- Assert reset while LOCKED mid-packet → locked=0, all cnt=4, ptr=0 immediately; first post-reset grant goes to the lowest-index requester.

Source files
------------

// File: rtl/oport_pck_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Package : oport_pck_arbiter_pkg
// Brief   : Width helpers and FSM encoding shared by the output-port schedulers.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package oport_pck_arbiter_pkg;

    // Ceiling log2 with a floor of one bit, so single-entry fields stay legal.
    function automatic int clog2_min1(input int x);
        int r;
        r = 1;
        while ((1 << r) < x) r++;
        return r;
    endfunction

    function automatic int vc_width(input int v);
        return clog2_min1(v);
    endfunction

    function automatic int cnt_width(input int b);
        return clog2_min1(b + 1);
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/oport_pck_arbiter_if.sv
//------------------------------------------------------------------------------
// Interface : oport_pck_arbiter_if
// Brief     : Request/grant/credit bundle between input ports and one output scheduler.
// Rev       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface oport_pck_arbiter_if #(
    parameter int V  = 4,
    parameter int N  = 4,
    parameter int VW = 2
);
    logic [N-1:0]    req;
    logic [N*VW-1:0] req_ovc;
    logic [N-1:0]    req_tail;
    logic [V-1:0]    credit_in;
    logic [N-1:0]    grant;
    logic [N-1:0]    xbar_sel;
    logic            flit_we_out;
    logic [V-1:0]    ovc_empty;
    logic            locked;
    logic            credit_err;

    modport master (
        output req, req_ovc, req_tail, credit_in,
        input  grant, xbar_sel, flit_we_out, ovc_empty, locked, credit_err
    );

    modport slave (
        input  req, req_ovc, req_tail, credit_in,
        output grant, xbar_sel, flit_we_out, ovc_empty, locked, credit_err
    );
endinterface

`default_nettype wire

// File: rtl/rr_fixed_ptr_arb.sv
//------------------------------------------------------------------------------
// Module : rr_fixed_ptr_arb
// Brief  : One-hot round-robin pick of the first request at or after i_ptr.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_fixed_ptr_arb
    import oport_pck_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2_min1(N)
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [PW-1:0] i_ptr,
    output logic      [N-1:0]  o_grant
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/oport_pck_arbiter.sv
//------------------------------------------------------------------------------
// Module : oport_pck_arbiter
// Brief  : Per-output-port packet scheduler with wormhole lock and VC credits.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module oport_pck_arbiter
    import oport_pck_arbiter_pkg::*;
#(
    parameter int V = 4,
    parameter int N = 4,
    parameter int B = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    oport_pck_arbiter_if.slave  bus
);

    localparam int VW = vc_width(V);
    localparam int CW = cnt_width(B);
    localparam int PW = clog2_min1(N);
    localparam logic [CW-1:0] C_FULL = CW'(B);

    state_t                r_state;
    logic [PW-1:0]         r_owner;
    logic [PW-1:0]         r_ptr;
    logic [N-1:0]          r_xbar_sel;
    logic                  r_we;
    logic                  r_credit_err;

    logic [V-1:0][CW-1:0]  w_cnt;
    logic [N-1:0]          w_elig;
    logic [N-1:0]          w_arb_grant;
    logic [N-1:0]          w_grant;
    logic [PW-1:0]         w_gidx;
    logic                  w_any;
    logic                  w_gtail;
    logic [V-1:0]          w_dec;
    logic [V-1:0]          w_err;

    for (genvar gi = 0; gi < N; gi++) begin : g_elig
        logic [VW-1:0] w_ovc;
        assign w_ovc       = bus.req_ovc[gi*VW +: VW];
        assign w_elig[gi]  = bus.req[gi] && (w_cnt[w_ovc] != '0) &&
                             ((r_state == ST_IDLE) || (r_owner == PW'(gi)));
    end

    rr_fixed_ptr_arb #(.N(N), .PW(PW)) u_arb (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant)
    );

    // Grant is forced low while reset is held so nothing upstream dequeues.
    assign w_grant = reset ? '0 : w_arb_grant;
    assign w_any   = |w_grant;
    assign w_gtail = |(w_grant & bus.req_tail);

    always_comb begin
        w_gidx = '0;
        w_dec  = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_gidx = PW'(i);
                w_dec[bus.req_ovc[i*VW +: VW]] = 1'b1;
            end
        end
    end

    for (genvar gv = 0; gv < V; gv++) begin : g_cnt
        logic [CW-1:0] r_cnt;

        assign w_err[gv] = bus.credit_in[gv] && !w_dec[gv] && (r_cnt == C_FULL);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= C_FULL;
            end else if (w_dec[gv] && !bus.credit_in[gv]) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (!w_dec[gv] && bus.credit_in[gv] && (r_cnt != C_FULL)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_cnt[gv]         = r_cnt;
        assign bus.ovc_empty[gv] = (r_cnt == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_xbar_sel   <= '0;
            r_we         <= 1'b0;
            r_credit_err <= 1'b0;
        end else begin
            r_xbar_sel <= w_grant;
            r_we       <= w_any;
            if (|w_err) begin
                r_credit_err <= 1'b1;
            end
            if (w_any) begin
                if ((r_state == ST_IDLE) && !w_gtail) begin
                    r_state <= ST_LOCKED;
                    r_owner <= w_gidx;
                end else if ((r_state == ST_LOCKED) && w_gtail) begin
                    r_state <= ST_IDLE;
                end
            end
            // Only a completed packet advances fairness.
            if (w_gtail) begin
                r_ptr <= (w_gidx == PW'(N-1)) ? '0 : w_gidx + 1'b1;
            end
        end
    end

    assign bus.grant       = w_grant;
    assign bus.xbar_sel    = r_xbar_sel;
    assign bus.flit_we_out = r_we;
    assign bus.locked      = (r_state == ST_LOCKED);
    assign bus.credit_err  = r_credit_err;

endmodule

`default_nettype wire

// File: tb/tb_oport_pck_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_oport_pck_arbiter
// Brief  : Directed and randomized checks of oport_pck_arbiter against a packet-level model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_oport_pck_arbiter;

    localparam int V  = 4;
    localparam int N  = 4;
    localparam int B  = 4;
    localparam int VW = 2;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    oport_pck_arbiter_if #(.V(V), .N(N), .VW(VW)) bus ();

    oport_pck_arbiter #(.V(V), .N(N), .B(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet-level reference state.
    int           m_cnt [V];
    bit           m_locked;
    int           m_owner;
    int           m_ptr;
    bit           m_err;
    logic [N-1:0] m_prev;

    logic [N-1:0] obs_grant;
    logic [N-1:0] obs_xbar;
    logic         obs_locked;
    logic [V-1:0] obs_empty;
    logic         obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < V; v++) m_cnt[v] = B;
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_err    = 1'b0;
        m_prev   = '0;
    endtask

    task automatic drive_idle();
        bus.req       = '0;
        bus.req_ovc   = '0;
        bus.req_tail  = '0;
        bus.credit_in = '0;
    endtask

    // Called at posedge+1; leaves time at the next posedge+1.
    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        #1;
        chk("rst_grant",  bus.grant,       0);
        chk("rst_xbar",   bus.xbar_sel,    0);
        chk("rst_we",     bus.flit_we_out, 0);
        chk("rst_empty",  bus.ovc_empty,   0);
        chk("rst_locked", bus.locked,      0);
        chk("rst_err",    bus.credit_err,  0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One cycle: drive, compare everything at negedge, advance the model.
    task automatic do_cycle(input logic [N-1:0] r, input logic [N*VW-1:0] o,
                            input logic [N-1:0] t, input logic [V-1:0] c);
        int           g;
        int           idx;
        int           ov;
        logic [N-1:0] exp_g;
        logic [V-1:0] exp_e;
        bit           dec;
        bus.req       = r;
        bus.req_ovc   = o;
        bus.req_tail  = t;
        bus.credit_in = c;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            ov  = int'(o[idx*VW +: VW]);
            if (g < 0 && r[idx] && m_cnt[ov] != 0 && (!m_locked || m_owner == idx)) g = idx;
        end
        exp_g = '0;
        if (g >= 0) exp_g[g] = 1'b1;
        for (int v = 0; v < V; v++) exp_e[v] = (m_cnt[v] == 0);
        chk("grant",      bus.grant,       exp_g);
        chk("xbar_sel",   bus.xbar_sel,    m_prev);
        chk("flit_we",    bus.flit_we_out, |m_prev);
        chk("ovc_empty",  bus.ovc_empty,   exp_e);
        chk("locked",     bus.locked,      m_locked);
        chk("credit_err", bus.credit_err,  m_err);
        obs_grant  = bus.grant;
        obs_xbar   = bus.xbar_sel;
        obs_locked = bus.locked;
        obs_empty  = bus.ovc_empty;
        obs_err    = bus.credit_err;
        if (g >= 0) begin
            if (!m_locked && !t[g]) begin
                m_locked = 1'b1;
                m_owner  = g;
            end else if (m_locked && t[g]) begin
                m_locked = 1'b0;
            end
            if (t[g]) m_ptr = (g + 1) % N;
        end
        for (int v = 0; v < V; v++) begin
            dec = (g >= 0) && (int'(o[g*VW +: VW]) == v);
            if (dec && !c[v]) m_cnt[v]--;
            else if (!dec && c[v]) begin
                if (m_cnt[v] == B) m_err = 1'b1;
                else m_cnt[v]++;
            end
        end
        m_prev = exp_g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0]    rr;
        logic [N*VW-1:0] ro;
        logic [N-1:0]    rt;
        logic [V-1:0]    rc;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive_idle();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Two single-flit packets on VC 0.
        do_cycle(4'b0101, 8'h00, 4'b0101, 4'b0000);
        chk("t1_g0", obs_grant, 4'b0001);
        do_cycle(4'b0101, 8'h00, 4'b0101, 4'b0000);
        chk("t1_g1", obs_grant, 4'b0100);
        chk("t1_x0", obs_xbar,  4'b0001);
        do_cycle(4'b0000, 8'h00, 4'b0000, 4'b0000);
        chk("t1_x1", obs_xbar,  4'b0100);

        // Three-flit packet from input 1 while input 2 keeps requesting.
        do_cycle(4'b0110, 8'h24, 4'b0100, 4'b0000);
        chk("t2_g0", obs_grant, 4'b0010);
        chk("t2_l0", obs_locked, 1'b0);
        do_cycle(4'b0110, 8'h24, 4'b0100, 4'b0000);
        chk("t2_g1", obs_grant, 4'b0010);
        chk("t2_l1", obs_locked, 1'b1);
        do_cycle(4'b0110, 8'h24, 4'b0110, 4'b0000);
        chk("t2_g2", obs_grant, 4'b0010);
        chk("t2_l2", obs_locked, 1'b1);
        do_cycle(4'b0100, 8'h24, 4'b0100, 4'b0000);
        chk("t2_g3", obs_grant, 4'b0100);
        chk("t2_l3", obs_locked, 1'b0);

        // Drain VC 2, then a credit makes it grantable one cycle later.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_cycle(4'b0001, 8'h02, 4'b0001, 4'b0000);
            chk("t3_g", obs_grant, 4'b0001);
        end
        do_cycle(4'b0001, 8'h02, 4'b0001, 4'b0000);
        chk("t3_stall", obs_grant, 4'b0000);
        chk("t3_empty", obs_empty, 4'b0100);
        do_cycle(4'b0001, 8'h02, 4'b0001, 4'b0100);
        chk("t3_same", obs_grant, 4'b0000);
        do_cycle(4'b0001, 8'h02, 4'b0001, 4'b0000);
        chk("t3_next", obs_grant, 4'b0001);

        // Simultaneous decrement and credit on VC 1 leaves the count at 2.
        do_reset();
        do_cycle(4'b0001, 8'h01, 4'b0001, 4'b0000);
        do_cycle(4'b0001, 8'h01, 4'b0001, 4'b0000);
        do_cycle(4'b0001, 8'h01, 4'b0001, 4'b0010);
        chk("t4_both", obs_grant, 4'b0001);
        do_cycle(4'b0001, 8'h01, 4'b0001, 4'b0000);
        chk("t4_g0", obs_grant, 4'b0001);
        do_cycle(4'b0001, 8'h01, 4'b0001, 4'b0000);
        chk("t4_g1", obs_grant, 4'b0001);
        do_cycle(4'b0001, 8'h01, 4'b0001, 4'b0000);
        chk("t4_stall", obs_grant, 4'b0000);

        // Credit overflow on a full VC is sticky and does not raise the count.
        do_reset();
        do_cycle(4'b0000, 8'h00, 4'b0000, 4'b1000);
        do_cycle(4'b0000, 8'h00, 4'b0000, 4'b0000);
        chk("t5_err", obs_err, 1'b1);
        for (int k = 0; k < 4; k++) do_cycle(4'b0001, 8'h03, 4'b0001, 4'b0000);
        do_cycle(4'b0001, 8'h03, 4'b0001, 4'b0000);
        chk("t5_stall", obs_grant, 4'b0000);
        chk("t5_sticky", obs_err, 1'b1);

        // Randomized traffic with well-behaved credit returns.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rr = N'($urandom_range(0, 15));
            ro = (N*VW)'($urandom);
            rt = N'($urandom_range(0, 15));
            for (int v = 0; v < V; v++) rc[v] = (m_cnt[v] < B) && ($urandom_range(0, 2) == 0);
            do_cycle(rr, ro, rt, rc);
        end

        // Asynchronous reset in the middle of a locked packet.
        do_reset();
        do_cycle(4'b0100, 8'h00, 4'b0100, 4'b0000);
        do_cycle(4'b1000, 8'h00, 4'b0000, 4'b0000);
        chk("t6_lockg", obs_grant, 4'b1000);
        reset = 1'b1;
        #1;
        chk("t6_locked", bus.locked,    0);
        chk("t6_grant",  bus.grant,     0);
        chk("t6_xbar",   bus.xbar_sel,  0);
        chk("t6_empty",  bus.ovc_empty, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_cycle(4'b1110, 8'h00, 4'b1110, 4'b0000);
        chk("t6_first", obs_grant, 4'b0010);
        do_cycle(4'b0000, 8'h00, 4'b0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
